// File: rtl/year_pkg.sv
// Shared types and constants for the calendar year stage.
// Op encoding for the two-phase latch/apply register, edit cursor codes, BCD helpers.
package year_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_TICK = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

    localparam logic [2:0]  POS_Y_UNITS     = 3'd4;
    localparam logic [2:0]  POS_Y_TENS      = 3'd5;
    localparam logic [2:0]  POS_Y_HUNDS     = 3'd6;
    localparam logic [2:0]  POS_Y_THOUS     = 3'd7;

    localparam logic [1:0]  EDIT_SCREEN_DEF = 2'd1;
    localparam logic [15:0] RESET_YEAR_DEF  = 16'h2000;

    // Divisibility by 4 of a two-digit BCD value without converting to binary.
    function automatic logic bcd_mod4_zero(input logic [3:0] tens, input logic [3:0] units);
        logic units_even_set;
        logic units_odd_set;
        units_even_set = (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
        units_odd_set  = (units == 4'd2) || (units == 4'd6);
        return tens[0] ? units_odd_set : units_even_set;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit: ripple increment when carry_in is set, otherwise isolated mod-10 inc/dec.
// carry_in takes precedence so a TICK never mixes with an edit.
module bcd_digit_step (
    input  logic [3:0] digit,
    input  logic       inc,
    input  logic       dec,
    input  logic       carry_in,
    output logic [3:0] digit_next,
    output logic       carry_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (digit == 4'd9) begin
                digit_next = 4'd0;
                carry_out  = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end else if (inc) begin
            digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
    end

endmodule

// File: rtl/year_counter.sv
// Calendar year stage: counts month-counter carries, supports per-digit front-panel edits.
// Leap flag is built only when YEAR_LEAP_EN is defined; otherwise it is tied low.
module year_counter
    import year_pkg::*;
#(
    parameter logic [15:0] RESET_YEAR  = RESET_YEAR_DEF,
    parameter logic [1:0]  EDIT_SCREEN = EDIT_SCREEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_year,
    input  logic        key_plus,
    input  logic        key_minus,
    input  logic [2:0]  edit_pos,
    input  logic        edit_mode,
    input  logic [1:0]  screen,
    output logic [15:0] years,
    output logic        leap,
    output logic        clk_century
);

    op_e         op_q, op_d;
    logic [1:0]  pos_q, pos_d;
    logic [15:0] years_q, years_d;
    logic        century_q, century_d;
    logic        key_plus_prev_q, key_plus_prev_d;
    logic        key_minus_prev_q, key_minus_prev_d;

    logic        plus_fall;
    logic        minus_fall;
    logic        edit_ok;
    logic [4:0]  carry;
    logic [15:0] years_step;

    assign carry[0] = (op_q == OP_TICK);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (years_q[4*i +: 4]),
            .inc        ((op_q == OP_INC) && (pos_q == 2'(i))),
            .dec        ((op_q == OP_DEC) && (pos_q == 2'(i))),
            .carry_in   (carry[i]),
            .digit_next (years_step[4*i +: 4]),
            .carry_out  (carry[i+1])
        );
    end

    always_comb begin
        plus_fall        = key_plus_prev_q & ~key_plus;
        minus_fall       = key_minus_prev_q & ~key_minus;
        edit_ok          = edit_mode && (screen == EDIT_SCREEN) && edit_pos[2];
        op_d             = OP_NONE;
        pos_d            = pos_q;
        key_plus_prev_d  = key_plus;
        key_minus_prev_d = key_minus;

        // A run tick always consumes the cycle, even when editing drops it.
        if (clk_year) begin
            op_d = edit_mode ? OP_NONE : OP_TICK;
        end else if (plus_fall) begin
            op_d  = edit_ok ? OP_INC : OP_NONE;
            pos_d = edit_pos[1:0];
        end else if (minus_fall) begin
            op_d  = edit_ok ? OP_DEC : OP_NONE;
            pos_d = edit_pos[1:0];
        end

        years_d   = years_step;
        century_d = (op_q == OP_TICK) && (years_step[7:0] == 8'h00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q             <= OP_NONE;
            pos_q            <= 2'd0;
            years_q          <= RESET_YEAR;
            century_q        <= 1'b0;
            key_plus_prev_q  <= 1'b1;
            key_minus_prev_q <= 1'b1;
        end else begin
            op_q             <= op_d;
            pos_q            <= pos_d;
            years_q          <= years_d;
            century_q        <= century_d;
            key_plus_prev_q  <= key_plus_prev_d;
            key_minus_prev_q <= key_minus_prev_d;
        end
    end

`ifdef YEAR_LEAP_EN
    // Century years (yy = 00) fall back to the cc mod 4 test.
    always_comb begin
        if (years_q[7:0] == 8'h00) begin
            leap = bcd_mod4_zero(years_q[15:12], years_q[11:8]);
        end else begin
            leap = bcd_mod4_zero(years_q[7:4], years_q[3:0]);
        end
    end
`else
    assign leap = 1'b0;
`endif

    assign years       = years_q;
    assign clk_century = century_q;

endmodule
